// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_ctrl_pkg                                                    |
// | Brief   : Shared state encoding and constants for the pipeline sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_t;

  localparam int          c_RA_W_DEFAULT = 5;
  // addi x0, x0, 0 -- what a flushed stage register carries
  localparam logic [31:0] c_NOP_INSN     = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/stall_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stall_timer                                                      |
// | Brief   : Loadable down-counter with zero flag; holds at zero.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stall_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_hazard_ctrl                                                 |
// | Brief   : Hold/bubble sequencer for IF/ID, ID/EX, EX/MEM, MEM/WB registers. |
// |           Optional stall_cycles counter when PIPE_PERF_CNT_EN is defined.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int RA_W        = c_RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_md_op,
  input  logic            ex_br_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            mem_timeout,
  output logic            md_busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  localparam int c_MD_W   = $clog2(MD_LATENCY);
  localparam int c_WAIT_W = 8;

  pipe_state_t         r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_timeout;

  logic w_md_zero;
  logic w_timeout_hit, w_mem_pending, w_mem_stall;
  logic w_md_start, w_md_hold, w_load_use, w_branch, w_lu_stall;
  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

  assign w_timeout_hit = (r_wait_cnt == c_WAIT_W'(MEM_TIMEOUT));
  assign w_mem_pending = mem_req & ~mem_ready;
  // A timed-out access is released exactly as if memory had answered
  assign w_mem_stall   = (r_state != MD_BUSY) & w_mem_pending & ~w_timeout_hit;
  assign w_md_start    = (r_state == RUN) & ex_md_op & ~w_mem_stall;
  assign w_md_hold     = (r_state == MD_BUSY) & ~w_md_zero;
  assign w_load_use    = ex_mem_read & (ex_rd != '0) &
                         ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign w_branch      = (r_state == RUN) & ex_br_taken & ~w_mem_stall & ~ex_md_op;
  assign w_lu_stall    = (r_state == RUN) & w_load_use & ~w_mem_stall & ~ex_md_op &
                         ~ex_br_taken;

  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_memwb_flush = 1'b0;
    if (w_mem_stall) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_en    = 1'b0;
      w_memwb_flush = 1'b1;
    end else if (w_md_start || w_md_hold) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_flush = 1'b1;
    end else if (w_branch) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
    end else if (w_lu_stall) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_flush  = 1'b1;
    end
  end

  // A flushed register must still load its NOP, so flush forces the enable
  assign pc_en       = rst_n & w_pc_en;
  assign ifid_en     = rst_n & (w_ifid_en  | w_ifid_flush);
  assign idex_en     = rst_n & (w_idex_en  | w_idex_flush);
  assign exmem_en    = rst_n & (w_exmem_en | w_exmem_flush);
  assign memwb_en    = rst_n & (w_memwb_en | w_memwb_flush);
  assign ifid_flush  = ~rst_n | w_ifid_flush;
  assign idex_flush  = ~rst_n | w_idex_flush;
  assign exmem_flush = ~rst_n | w_exmem_flush;
  assign memwb_flush = ~rst_n | w_memwb_flush;
  assign mem_timeout = r_mem_timeout;
  assign md_busy     = rst_n & (r_state == MD_BUSY);

  stall_timer #(
    .WIDTH    (c_MD_W)
  ) u_md_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_md_start),
    .load_val (c_MD_W'(MD_LATENCY - 2)),
    .dec      (w_md_hold),
    .zero     (w_md_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end else if (w_md_start) begin
            r_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (w_md_zero) r_state <= RUN;
        end
        MEM_WAIT: begin
          if (w_mem_stall) begin
            if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
          end else begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            if (w_timeout_hit && w_mem_pending) r_mem_timeout <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_en) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipe_hazard_ctrl                                              |
// | Brief   : Directed self-checking bench for pipe_hazard_ctrl.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  // {pc,ifid,idex,exmem,memwb}_en , {ifid,idex,exmem,memwb}_flush
  localparam logic [8:0] c_DEF = 9'b11111_0000;
  localparam logic [8:0] c_RST = 9'b00000_1111;
  localparam logic [8:0] c_LU  = 9'b00111_0100;
  localparam logic [8:0] c_BR  = 9'b11111_1100;
  localparam logic [8:0] c_MD  = 9'b00011_0010;
  localparam logic [8:0] c_MEM = 9'b00001_0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_md_op, ex_br_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       mem_timeout, md_busy;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MD_LATENCY  (4),
    .MEM_TIMEOUT (15),
    .RA_W        (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_md_op    (ex_md_op),
    .ex_br_taken (ex_br_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .mem_timeout (mem_timeout),
    .md_busy     (md_busy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_md_op = 1'b0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance one cycle; inputs are then changed 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    checks++; if (outs !== c_RST) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, c_RST); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
`endif
    step();
    step();
    rst_n = 1'b1;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL post_reset_outs: got %b want %b", outs, c_DEF); end
  endtask

  task automatic test_load_use();
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #2;
    checks++; if (outs !== c_LU) begin errors++; $display("FAIL lu_rs2: got %b want %b", outs, c_LU); end
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd9;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL lu_after_bubble: got %b want %b", outs, c_DEF); end
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd1;
    #2;
    checks++; if (outs !== c_LU) begin errors++; $display("FAIL lu_rs1: got %b want %b", outs, c_LU); end
    step();
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL lu_x0: got %b want %b", outs, c_DEF); end
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd4; id_rs1 = 5'd4;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL lu_not_load: got %b want %b", outs, c_DEF); end
    clear_inputs();
  endtask

  task automatic test_branch_over_lu();
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; ex_br_taken = 1'b1;
    #2;
    checks++; if (outs !== c_BR) begin errors++; $display("FAIL branch_lu: got %b want %b", outs, c_BR); end
    step();
    clear_inputs();
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL branch_after: got %b want %b", outs, c_DEF); end
  endtask

  // Cycle t: start; t+1..t+3 in MD_BUSY; flush at t..t+2, defaults at t+3
  task automatic run_md_op(input string tag);
    logic [8:0] exp_o [4] = '{c_MD, c_MD, c_MD, c_DEF};
    logic       exp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      ex_md_op = 1'b1;
      ex_br_taken = (i == 1);
      #2;
      checks++; if (outs !== exp_o[i]) begin errors++; $display("FAIL %s_t%0d_outs: got %b want %b", tag, i, outs, exp_o[i]); end
      checks++; if (md_busy !== exp_b[i]) begin errors++; $display("FAIL %s_t%0d_busy: got %b want %b", tag, i, md_busy, exp_b[i]); end
    end
    ex_br_taken = 1'b0;
  endtask

  task automatic test_muldiv();
    step();
    run_md_op("md");
    step();
    ex_md_op = 1'b0;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL md_t4_outs: got %b want %b", outs, c_DEF); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_t4_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_back_to_back();
    step();
    run_md_op("md_a");
    step();
    run_md_op("md_b");
    step();
    ex_md_op = 1'b0;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL b2b_end: got %b want %b", outs, c_DEF); end
  endtask

  task automatic test_mem_over_md();
    step();
    ex_md_op = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    #2;
    checks++; if (outs !== c_MEM) begin errors++; $display("FAIL mem_over_md: got %b want %b", outs, c_MEM); end
    step();
    mem_ready = 1'b1;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL mem_over_md_release: got %b want %b", outs, c_DEF); end
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    run_md_op("md_after_mem");
    step();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    step();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step();
      #2;
      checks++; if (outs !== c_MEM) begin errors++; $display("FAIL mem_wait_c%0d: got %b want %b", i, outs, c_MEM); end
    end
    step();
    mem_ready = 1'b1;
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL mem_release: got %b want %b", outs, c_DEF); end
    step();
    clear_inputs();
    #2;
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mem_no_timeout: got %b want 0", mem_timeout); end
  endtask

  task automatic test_timeout();
    step();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i != 0) step();
      #2;
      checks++; if (outs !== c_MEM) begin errors++; $display("FAIL to_wait_c%0d: got %b want %b", i, outs, c_MEM); end
    end
    step();
    #2;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL to_release: got %b want %b", outs, c_DEF); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_flag_early: got %b want 0", mem_timeout); end
    step();
    #2;
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_flag_set: got %b want 1", mem_timeout); end
    checks++; if (outs !== c_MEM) begin errors++; $display("FAIL to_rewait: got %b want %b", outs, c_MEM); end
    step();
    clear_inputs();
    step();
    #2;
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_flag_sticky: got %b want 1", mem_timeout); end
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL to_idle: got %b want %b", outs, c_DEF); end
  endtask

  task automatic test_reset_mid_md();
    step();
    ex_md_op = 1'b1;
    step();
    #2;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rst_md_pre_busy: got %b want 1", md_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (outs !== c_RST) begin errors++; $display("FAIL rst_md_outs: got %b want %b", outs, c_RST); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy: got %b want 0", md_busy); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_md_timeout: got %b want 0", mem_timeout); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_md_stall_cycles: got %0d want 0", stall_cycles); end
`endif
    ex_md_op = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL rst_md_release: got %b want %b", outs, c_DEF); end
    step();
    #2;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_run_busy: got %b want 0", md_busy); end
    checks++; if (outs !== c_DEF) begin errors++; $display("FAIL rst_md_run_outs: got %b want %b", outs, c_DEF); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_muldiv();
    test_back_to_back();
    test_mem_over_md();
    test_mem_wait();
    test_timeout();
    test_reset_mid_md();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
